pe_noc_packetizer: RTL and testbench

//  Clocked injection stage directly upstream of a tree router's parent-side input (P_in).

---
 rtl/pe_noc_packetizer.sv | 136 +++++++++++++
 tb/tb_pe_noc_packetizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_noc_packetizer.sv
// pe_noc_packetizer
//   Injection stage between a processing element and the parent-side input of a tree
//   router. PE requests (dest, type, payload) are formatted into 32-bit NoC packets and
//   queued in a small FIFO, then offered on a valid/ready interface toward the router
//   handshake bridge. Requests addressed to this node are acknowledged but dropped, and
//   counted in a saturating counter.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          PE request handshake
//   in_dest/in_type/in_payload request fields
//   out_valid/out_ready        packet handshake toward the router
//   out_data                   {type, 2'b00, dest, payload}; 0 while empty
//   fifo_count                 occupied FIFO entries, 0..DEPTH
//   drop_cnt                   self-addressed requests dropped, saturating

module pe_noc_packetizer #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [2:0]  NODE_ADDR = 3'b000,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_dest,
   input  logic [2:0]               in_type,
   input  logic [23:0]              in_payload,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      StEmpty,
      StActive,
      StFull
   } state_e;

   state_e           state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
   logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic [CNT_W-1:0] drop_nxt;
   logic [WIDTH-1:0] pkt;
   logic [WIDTH-1:0] head_nxt;
   logic             accept;
   logic             is_self;
   logic             push;
   logic             pop;

   // Full-ness comes from the registered FSM state, so in_ready never looks at in_valid.
   assign in_ready = (state != StFull) && rst_n;
   assign accept   = in_valid && in_ready;
   assign is_self  = (in_dest == NODE_ADDR);
   assign push     = accept && !is_self;
   assign pop      = out_valid && out_ready;
   assign pkt      = {in_type, 2'b00, in_dest, in_payload};

   always_comb begin
      rd_ptr_nxt = pop  ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr_nxt = push ? wr_ptr + AW'(1) : wr_ptr;
      count_nxt  = fifo_count + CW'(push) - CW'(pop);

      drop_nxt = drop_cnt;
      if (accept && is_self && (drop_cnt != '1)) begin
         drop_nxt = drop_cnt + CNT_W'(1);
      end

      state_nxt = state;
      unique case (state)
         StEmpty:  if (push) state_nxt = StActive;
         StActive: begin
            if (count_nxt == CW'(DEPTH)) begin
               state_nxt = StFull;
            end else if (count_nxt == '0) begin
               state_nxt = StEmpty;
            end
         end
         StFull:   if (pop) state_nxt = StActive;
         default:  state_nxt = StEmpty;
      endcase

      // Next head of queue. When the slot the read pointer moves to is the one being
      // written this cycle (queue was empty, or held one entry that is popping), the
      // memory does not hold it yet, so forward the incoming packet.
      if (count_nxt == '0) begin
         head_nxt = '0;
      end else if (push && (rd_ptr_nxt == wr_ptr)) begin
         head_nxt = pkt;
      end else begin
         head_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StEmpty;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_cnt   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         fifo_count <= count_nxt;
         drop_cnt   <= drop_nxt;
         out_valid  <= (count_nxt != '0);
         out_data   <= head_nxt;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pkt;
      end
   end

   out_data_known: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid |-> !$isunknown(out_data));

   out_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pe_noc_packetizer.sv
module tb_pe_noc_packetizer;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CNT_W   = 8;
   localparam logic [2:0]  NODE    = 3'b010;
   localparam int unsigned SAT_MAX = 255;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_dest = '0;
   logic [2:0]       in_type = '0;
   logic [23:0]      in_payload = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [2:0]       fifo_count;
   logic [CNT_W-1:0] drop_cnt;

   int passed = 0;
   int total  = 0;

   // Reference model: queue of formatted packets plus a saturating drop tally.
   logic [31:0] model_q[$];
   int unsigned model_drops = 0;

   pe_noc_packetizer #(
      .WIDTH     (32),
      .NODE_ADDR (NODE),
      .DEPTH     (DEPTH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dest    (in_dest),
      .in_type    (in_type),
      .in_payload (in_payload),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fmt(input logic [2:0] d, input logic [2:0] t,
                                       input logic [23:0] p);
      return {t, 2'b00, d, p};
   endfunction

   function automatic logic [31:0] model_head();
      return (model_q.size() != 0) ? model_q[0] : 32'h0;
   endfunction

   // Apply the handshake rules to the model for the coming edge, then advance one clock.
   task automatic tick();
      bit acc;
      bit pop;
      acc = (in_valid === 1'b1) && (rst_n === 1'b1) && (model_q.size() < DEPTH);
      pop = (out_ready === 1'b1) && (model_q.size() != 0);
      if (pop) void'(model_q.pop_front());
      if (acc) begin
         if (in_dest == NODE) begin
            if (model_drops < SAT_MAX) model_drops++;
         end else begin
            model_q.push_back(fmt(in_dest, in_type, in_payload));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_dest = 3'b001; in_type = 3'b000; in_payload = 24'h5;
      out_ready = 1'b1;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0h want 0", in_ready); else passed++;
      total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
      total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else passed++;
      total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %0h want 0", out_data); else passed++;
      rst_n = 1'b1; in_valid = 1'b0;
      model_q.delete(); model_drops = 0;
      tick();
      total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %0h want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL release_out_valid got %0h want 0", out_valid); else passed++;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid = 1'b1; in_dest = 3'b001; in_type = 3'b000; in_payload = 24'h9;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0h want 1", out_valid); else passed++;
      total++; if (out_data !== 32'h01000009) $display("FAIL single_data got %08h want 01000009", out_data); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL single_gone got %0h want 0", out_valid); else passed++;
      total++; if (out_data !== 32'h0) $display("FAIL single_empty_data got %08h want 0", out_data); else passed++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_dest = 3'b101; in_type = 3'b011;
      for (int i = 1; i <= 5; i++) begin
         in_payload = 24'(i);
         tick();
      end
      // Fifth request is still pending (refused while full); keep it offered.
      total++; if (fifo_count !== 3'd4) $display("FAIL bp_count got %0d want 4", fifo_count); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %0h want 0", in_ready); else passed++;
      total++; if (out_data !== fmt(3'b101, 3'b011, 24'd1)) $display("FAIL bp_head got %08h want %08h", out_data, fmt(3'b101, 3'b011, 24'd1)); else passed++;
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== fmt(3'b101, 3'b011, 24'd1)) $display("FAIL bp_hold got %0h/%08h want 1/%08h", out_valid, out_data, fmt(3'b101, 3'b011, 24'd1)); else passed++;
      out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         total++; if (out_valid !== 1'b1 || out_data !== fmt(3'b101, 3'b011, 24'(k))) $display("FAIL bp_stream_%0d got %0h/%08h want 1/%08h", k, out_valid, out_data, fmt(3'b101, 3'b011, 24'(k))); else passed++;
         tick();
         if (k == 2) in_valid = 1'b0;
      end
      total++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %0h want 0", out_valid); else passed++;
   endtask

   task automatic test_full_simul();
      logic [23:0] exp_p[4];
      out_ready = 1'b0;
      in_valid = 1'b1; in_dest = 3'b111; in_type = 3'b001;
      for (int i = 1; i <= 4; i++) begin
         in_payload = 24'h100 + 24'(i);
         tick();
      end
      total++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) $display("FAIL fs_full got count %0d ready %0h want 4/0", fifo_count, in_ready); else passed++;
      in_payload = 24'h1FF;
      out_ready = 1'b1;
      tick();
      total++; if (fifo_count !== 3'd3) $display("FAIL fs_pop_only got %0d want 3", fifo_count); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL fs_ready_rise got %0h want 1", in_ready); else passed++;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      total++; if (fifo_count !== 3'd4) $display("FAIL fs_refill got %0d want 4", fifo_count); else passed++;
      exp_p[0] = 24'h102; exp_p[1] = 24'h103; exp_p[2] = 24'h104; exp_p[3] = 24'h1FF;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (out_data !== fmt(3'b111, 3'b001, exp_p[k])) $display("FAIL fs_order_%0d got %08h want %08h", k, out_data, fmt(3'b111, 3'b001, exp_p[k])); else passed++;
         tick();
      end
      total++; if (out_valid !== 1'b0) $display("FAIL fs_drained got %0h want 0", out_valid); else passed++;
   endtask

   task automatic test_drop();
      out_ready = 1'b1;
      in_valid = 1'b1; in_dest = NODE; in_type = 3'b110; in_payload = 24'hABCDEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL drop_cycle_%0d got valid %0h ready %0h want 0/1", i, out_valid, in_ready); else passed++;
      end
      in_valid = 1'b0;
      total++; if (drop_cnt !== 8'd3) $display("FAIL drop_cnt got %0d want 3", drop_cnt); else passed++;
      total++; if (fifo_count !== 3'd0) $display("FAIL drop_count got %0d want 0", fifo_count); else passed++;
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      in_valid = 1'b1; in_dest = 3'b011;
      for (int i = 0; i < 10; i++) begin
         in_type = 3'(i);
         in_payload = 24'h00A000 + 24'(i);
         tick();
         total++; if (out_data !== fmt(3'b011, 3'(i), 24'h00A000 + 24'(i)) || fifo_count !== 3'd1) $display("FAIL wrap_%0d got %08h cnt %0d want %08h cnt 1", i, out_data, fifo_count, fmt(3'b011, 3'(i), 24'h00A000 + 24'(i))); else passed++;
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL wrap_drained got %0h want 0", out_valid); else passed++;
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_dest = 3'b100; in_type = 3'b010;
      for (int i = 0; i < 3; i++) begin
         in_payload = 24'h777000 + 24'(i);
         tick();
      end
      in_valid = 1'b0;
      total++; if (fifo_count !== 3'd3) $display("FAIL mr_pre_count got %0d want 3", fifo_count); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) $display("FAIL mr_clear got cnt %0d valid %0h want 0/0", fifo_count, out_valid); else passed++;
      total++; if (in_ready !== 1'b0 || out_data !== 32'h0) $display("FAIL mr_outputs got ready %0h data %08h want 0/0", in_ready, out_data); else passed++;
      model_q.delete(); model_drops = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) $display("FAIL mr_no_replay_%0d got %0h want 0", i, out_valid); else passed++;
      end
      total++; if (drop_cnt !== 8'd0) $display("FAIL mr_drop_cleared got %0d want 0", drop_cnt); else passed++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         if (in_valid) begin
            in_dest = 3'($urandom_range(0, 7));
            in_type = 3'($urandom_range(0, 7));
            in_payload = 24'($urandom);
         end else begin
            in_dest = 'x; in_type = 'x; in_payload = 'x;
         end
         out_ready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         total++; if (in_ready !== (model_q.size() < DEPTH)) $display("FAIL rnd_ready_%0d got %0h want %0h", n, in_ready, (model_q.size() < DEPTH)); else passed++;
         tick();
         total++; if (out_valid !== (model_q.size() != 0) || out_data !== model_head()) $display("FAIL rnd_out_%0d got %0h/%08h want %0h/%08h", n, out_valid, out_data, (model_q.size() != 0), model_head()); else passed++;
         total++; if (fifo_count !== 3'(model_q.size()) || drop_cnt !== 8'(model_drops)) $display("FAIL rnd_cnt_%0d got %0d/%0d want %0d/%0d", n, fifo_count, drop_cnt, model_q.size(), model_drops); else passed++;
      end
      in_valid = 1'b0; in_dest = '0; in_type = '0; in_payload = '0;
   endtask

   task automatic test_drop_sat();
      out_ready = 1'b1;
      in_valid = 1'b1; in_dest = NODE; in_type = 3'b000; in_payload = 24'h1;
      for (int i = 0; i < 260; i++) tick();
      in_valid = 1'b0;
      total++; if (drop_cnt !== 8'hFF) $display("FAIL sat_drop got %0d want 255", drop_cnt); else passed++;
      tick();
      total++; if (drop_cnt !== 8'(model_drops) || out_valid !== 1'b0) $display("FAIL sat_hold got %0d/%0h want %0d/0", drop_cnt, out_valid, model_drops); else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full_simul();
      test_drop();
      test_wrap();
      test_mid_reset();
      test_random();
      test_drop_sat();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
